// File: rtl/gsensor_spi_master.sv
// gsensor_spi_master: mode-3 SPI master issuing single-register ADXL345 reads/writes
module gsensor_spi_master #(
    parameter int CLK_DIV = 25
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       GSENSOR_CS_N,
    output logic       GSENSOR_SCLK,
    output logic       GSENSOR_SDI,
    input  logic       GSENSOR_SDO
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic          high_half;
    logic [15:0]   sr;
    logic          cnt_last;
    assign cnt_last = cnt == CNT_MAX;
    // sr shifts SDO in on each SCLK rise, so sr[15] is always the next bit to present on SDI
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            high_half    <= 1'b0;
            sr           <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            GSENSOR_CS_N <= 1'b1;
            GSENSOR_SCLK <= 1'b1;
            GSENSOR_SDI  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            cnt       <= (state == S_IDLE || cnt_last) ? '0 : cnt + CW'(1);
            case (state)
                S_IDLE: if (cmd_valid) begin
                    state        <= S_SETUP;
                    cmd_ready    <= 1'b0;
                    busy         <= 1'b1;
                    GSENSOR_CS_N <= 1'b0;
                    GSENSOR_SDI  <= cmd_rw;
                    sr           <= {cmd_rw, 1'b0, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
                end
                S_SETUP: if (cnt_last) begin
                    state        <= S_SHIFT;
                    GSENSOR_SCLK <= 1'b0;
                    high_half    <= 1'b0;
                    bit_cnt      <= '0;
                end
                S_SHIFT: if (cnt_last) begin
                    if (!high_half) begin
                        GSENSOR_SCLK <= 1'b1;
                        high_half    <= 1'b1;
                        sr           <= {sr[14:0], GSENSOR_SDO};
                    end else if (bit_cnt == 4'd15) begin
                        state <= S_HOLD;
                    end else begin
                        GSENSOR_SCLK <= 1'b0;
                        high_half    <= 1'b0;
                        bit_cnt      <= bit_cnt + 4'd1;
                        GSENSOR_SDI  <= sr[15];
                    end
                end
                S_HOLD: if (cnt_last) begin
                    state        <= S_GAP;
                    GSENSOR_CS_N <= 1'b1;
                    GSENSOR_SDI  <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= sr[7:0];
                end
                S_GAP: if (cnt_last) begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gsensor_spi_master.sv
// tb_gsensor_spi_master: random register traffic against an ADXL345-like slave with a scoreboard
module tb_gsensor_spi_master;
    localparam int CLK_DIV = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       cs_n;
    logic       sclk;
    logic       sdi;
    logic       sdo = 1'b1;

    gsensor_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .GSENSOR_CS_N(cs_n),
        .GSENSOR_SCLK(sclk),
        .GSENSOR_SDI(sdi),
        .GSENSOR_SDO(sdo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int n_abort = 0;
    int cyc = 0;
    bit in_abort = 1'b0;
    bit b2b = 1'b0;

    logic [15:0] exp_frame_q[$];
    logic [7:0]  exp_rsp_q[$];
    int          acc_q[$];
    logic [7:0]  model [64];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register-file view of the sensor: a frame reads back the current value, a write then replaces it
    always @(posedge clk) begin
        cyc++;
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_frame_q.push_back({cmd_rw, 1'b0, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata});
            exp_rsp_q.push_back(model[cmd_addr]);
            if (!cmd_rw) model[cmd_addr] = cmd_wdata;
            acc_q.push_back(cyc);
            n_acc++;
        end
    end

    // Mode-3 slave: captures SDI on rises, drives register data on falls after the header byte
    logic [7:0]  smem [64];
    logic [15:0] s_rx = '0;
    logic [5:0]  s_addr = '0;
    int          s_rises = 0;
    int          s_falls = 0;

    always @(negedge cs_n) begin
        s_rises = 0;
        s_falls = 0;
        s_rx = '0;
    end
    always @(posedge sclk) if (!cs_n) begin
        s_rx = {s_rx[14:0], sdi};
        s_rises++;
    end
    always @(negedge sclk) if (!cs_n) begin
        s_falls++;
        if (s_falls == 9) s_addr = s_rx[5:0];
        sdo = (s_falls >= 9 && s_falls <= 16) ? smem[s_addr][16-s_falls] : 1'($urandom);
    end
    always @(posedge cs_n) if (rst_n && !in_abort) begin
        chk("frame_sclk_rises", s_rises, 16);
        if (exp_frame_q.size() == 0) chk("frame_unexpected", 1, 0);
        else chk("frame_bits", s_rx, exp_frame_q.pop_front());
        if (!s_rx[15]) smem[s_rx[13:8]] = s_rx[7:0];
    end

    // Monitor: response scoreboard plus pin-timing checks, sampled mid-cycle
    bit         prev_cs = 1'b1;
    bit         prev_ready = 1'b1;
    bit         prev_sclk = 1'b1;
    bit         prev_sdi = 1'b0;
    int         run = 0;
    int         sdi_age = 100;
    int         mon_rises = 0;
    int         cs_rise_cyc = 0;
    logic [7:0] last_rdata = 8'h00;

    always @(negedge clk) begin
        if (!rst_n || in_abort) begin
            run = 0;
            sdi_age = 100;
            mon_rises = 0;
        end else begin
            chk("busy_vs_ready", busy, !cmd_ready);
            if (rsp_valid) begin
                n_rsp++;
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_rdata", rsp_rdata, exp_rsp_q.pop_front());
                if (acc_q.size() > 0) chk("rsp_latency", cyc - acc_q[0], 34 * CLK_DIV);
                last_rdata = rsp_rdata;
            end
            if (cmd_ready && !prev_ready && acc_q.size() > 0) begin
                chk("ready_latency", cyc - acc_q.pop_front(), 35 * CLK_DIV);
                chk("rdata_hold", rsp_rdata, last_rdata);
            end
            if (cs_n && !prev_cs) begin
                cs_rise_cyc = cyc;
                if (acc_q.size() > 0) chk("cs_low_time", cyc - acc_q[0], 34 * CLK_DIV);
            end
            if (!cs_n && prev_cs) begin
                mon_rises = 0;
                if (b2b) begin
                    chk("b2b_cs_gap", cyc - cs_rise_cyc, CLK_DIV + 1);
                    b2b = 1'b0;
                end
            end
            if (cs_n) chk("sclk_idle_high", sclk, 1);
            if (sclk != prev_sclk) begin
                if (!prev_sclk) begin
                    chk("sclk_low_time", run, CLK_DIV);
                    chk("sdi_setup", (sdi == prev_sdi && sdi_age >= CLK_DIV), 1);
                    mon_rises++;
                end else if (mon_rises > 0) begin
                    chk("sclk_high_time", run, CLK_DIV);
                end
                run = 1;
            end else begin
                run++;
            end
            sdi_age = (sdi != prev_sdi) ? 1 : sdi_age + 1;
        end
        prev_cs = rst_n ? cs_n : 1'b1;
        prev_ready = rst_n ? cmd_ready : 1'b1;
        prev_sclk = rst_n ? sclk : 1'b1;
        prev_sdi = rst_n ? sdi : 1'b0;
    end

    // Called at a negedge; returns at the negedge following acceptance
    task automatic send(input logic rw, input logic [5:0] a, input logic [7:0] d, input bit keep);
        int t = 0;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("send_accept_timeout", 0, 1);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_rsp_q.size() > 0 || !cmd_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) smem[i] = 8'($urandom);
        smem[0] = 8'hE5;
        for (int i = 0; i < 64; i++) model[i] = smem[i];
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_cs_n", cs_n, 1);
        chk("reset_sclk", sclk, 1);
        chk("reset_sdi", sdi, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, 6'h00, 8'h5A, 1'b0);
        drain();
        send(1'b0, 6'h2D, 8'h08, 1'b0);
        drain();
        send(1'b1, 6'h2D, 8'h00, 1'b0);
        drain();
        // A command offered mid-frame must be ignored entirely
        send(1'b0, 6'h1E, 8'($urandom), 1'b0);
        repeat (CLK_DIV * 6) @(negedge clk);
        cmd_rw = 1'b0;
        cmd_addr = 6'h31;
        cmd_wdata = 8'hFF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();
        send(1'b0, 6'h2C, 8'h0A, 1'b1);
        @(negedge clk);
        b2b = 1'b1;
        send(1'b1, 6'h2C, 8'h00, 1'b0);
        drain();
        for (int i = 0; i < 24; i++) begin
            send(1'($urandom), 6'($urandom), 8'($urandom), (i < 23) && ($urandom % 3 == 0));
            if (!cmd_valid) repeat ($urandom % 5) @(negedge clk);
        end
        drain();
        // Abort a read mid-frame with reset, then confirm recovery
        send(1'b1, 6'h00, 8'h00, 1'b0);
        for (int t = 0; t < 1000 && s_rises < 7; t++) @(negedge clk);
        chk("abort_reached_bit7", s_rises, 7);
        in_abort = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        exp_frame_q.delete();
        exp_rsp_q.delete();
        acc_q.delete();
        n_abort++;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        in_abort = 1'b0;
        send(1'b1, 6'h00, 8'h00, 1'b0);
        drain();
        chk("rsp_count", n_rsp, n_acc - n_abort);
        chk("frames_left", exp_frame_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
